// File: rtl/decode_stage_p.sv
// Decode stage: instruction decode, register file, operand forwarding,
// branch/jump redirect and the ID/EX pipeline register.
module decode_stage_p #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           instr,
   input  logic [DATA_W-1:0]     pc_plus_4,
   input  logic                  id_valid,
   input  logic                  stall_id,
   input  logic                  flush_ex,
   input  logic                  wb_wr_en,
   input  logic [REG_ADDR_W-1:0] wb_wr_addr,
   input  logic [DATA_W-1:0]     wb_wr_data,
   input  logic [DATA_W-1:0]     mem_alu_result,
   input  logic [1:0]            forward_a_id,
   input  logic [1:0]            forward_b_id,
   output logic [REG_ADDR_W-1:0] id_rs,
   output logic [REG_ADDR_W-1:0] id_rt,
   output logic                  id_branch,
   output logic                  id_jump,
   output logic                  id_pc_src,
   output logic [DATA_W-1:0]     id_pc_branch,
   output logic [DATA_W-1:0]     id_pc_jump,
   output logic                  ex_valid,
   output logic                  ex_illegal,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_wr_en,
   output logic                  ex_alu_src_sel,
   output logic                  ex_reg_wr_en,
   output logic [2:0]            ex_alu_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_reg_wr_addr,
   output logic [DATA_W-1:0]     ex_reg_data1,
   output logic [DATA_W-1:0]     ex_reg_data2,
   output logic [DATA_W-1:0]     ex_sign_imm_ext
);

   localparam int NREG = 2 ** REG_ADDR_W;

   typedef struct packed {
      logic                  valid;
      logic                  illegal;
      logic                  m2r;
      logic                  mwr;
      logic                  asrc;
      logic                  rwr;
      logic [2:0]            alu;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] wa;
      logic [DATA_W-1:0]     d1;
      logic [DATA_W-1:0]     d2;
      logic [DATA_W-1:0]     imm;
   } id_ex_t;

   logic [DATA_W-1:0]     rf [NREG];
   logic [DATA_W-1:0]     rf_a, rf_b, op1, op2, sign_imm;
   logic [REG_ADDR_W-1:0] a_rd;
   logic [5:0]            op, funct;
   logic                  beq, bne, jmp, go;
   id_ex_t                dec, ex_q;

   assign op       = instr[31:26];
   assign funct    = instr[5:0];
   assign id_rs    = REG_ADDR_W'(instr[25:21]);
   assign id_rt    = REG_ADDR_W'(instr[20:16]);
   assign a_rd     = REG_ADDR_W'(instr[15:11]);
   assign sign_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_wr_en && wb_wr_addr != '0) begin
         rf[wb_wr_addr] <= wb_wr_data;
      end
   end

   // write-through so a same-cycle WB result is seen by this instruction
   assign rf_a = (id_rs == '0) ? '0 :
                 (wb_wr_en && wb_wr_addr == id_rs) ? wb_wr_data : rf[id_rs];
   assign rf_b = (id_rt == '0) ? '0 :
                 (wb_wr_en && wb_wr_addr == id_rt) ? wb_wr_data : rf[id_rt];

   function automatic logic [DATA_W-1:0] fwd(
      input logic [1:0]        sel,
      input logic [DATA_W-1:0] rv,
      input logic [DATA_W-1:0] mv,
      input logic [DATA_W-1:0] wv
   );
      if (!FWD_EN) return rv;
      unique case (sel)
         2'b01:   return mv;
         2'b10:   return wv;
         default: return rv;
      endcase
   endfunction

   assign op1 = fwd(forward_a_id, rf_a, mem_alu_result, wb_wr_data);
   assign op2 = fwd(forward_b_id, rf_b, mem_alu_result, wb_wr_data);

   always_comb begin
      dec = '0;
      beq = 1'b0;
      bne = 1'b0;
      jmp = 1'b0;
      unique case (1'b1)
         op == 6'b000000: begin
            dec.rwr = 1'b1;
            dec.wa  = a_rd;
            unique case (funct)
               6'b100000: dec.alu = 3'b010;
               6'b100010: dec.alu = 3'b110;
               6'b100100: dec.alu = 3'b000;
               6'b100101: dec.alu = 3'b001;
               6'b101010: dec.alu = 3'b111;
               default: begin
                  dec.rwr     = 1'b0;
                  dec.wa      = '0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         op == 6'b100011: begin
            dec.alu  = 3'b010;
            dec.asrc = 1'b1;
            dec.m2r  = 1'b1;
            dec.rwr  = 1'b1;
            dec.wa   = id_rt;
         end
         op == 6'b101011: begin
            dec.alu  = 3'b010;
            dec.asrc = 1'b1;
            dec.mwr  = 1'b1;
         end
         op == 6'b001000: begin
            dec.alu  = 3'b010;
            dec.asrc = 1'b1;
            dec.rwr  = 1'b1;
            dec.wa   = id_rt;
         end
         op == 6'b000100: begin
            dec.alu = 3'b110;
            beq     = 1'b1;
         end
         op == 6'b000101: begin
            dec.alu = 3'b110;
            bne     = 1'b1;
         end
         op == 6'b000010: jmp = 1'b1;
         default: dec.illegal = 1'b1;
      endcase
      dec.valid = 1'b1;
      dec.rs    = id_rs;
      dec.rt    = id_rt;
      dec.d1    = op1;
      dec.d2    = op2;
      dec.imm   = sign_imm;
      if (!id_valid) dec = '0;
   end

   assign go           = id_valid & ~stall_id;
   assign id_branch    = go & (beq | bne);
   assign id_jump      = go & jmp;
   assign id_pc_src    = go & ((beq & (op1 == op2)) | (bne & (op1 != op2)));
   assign id_pc_branch = pc_plus_4 + (sign_imm << 2);
   assign id_pc_jump   = {pc_plus_4[DATA_W-1:28], instr[25:0], 2'b00};

   // flush wins over stall, so flush+stall still inserts a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= '0;
      end else if (flush_ex) begin
         ex_q <= '0;
      end else if (!stall_id) begin
         ex_q <= dec;
      end
   end

   assign ex_valid        = ex_q.valid;
   assign ex_illegal      = ex_q.illegal;
   assign ex_mem_to_reg   = ex_q.m2r;
   assign ex_mem_wr_en    = ex_q.mwr;
   assign ex_alu_src_sel  = ex_q.asrc;
   assign ex_reg_wr_en    = ex_q.rwr;
   assign ex_alu_ctrl     = ex_q.alu;
   assign ex_rs           = ex_q.rs;
   assign ex_rt           = ex_q.rt;
   assign ex_reg_wr_addr  = ex_q.wa;
   assign ex_reg_data1    = ex_q.d1;
   assign ex_reg_data2    = ex_q.d2;
   assign ex_sign_imm_ext = ex_q.imm;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: vector table plus hand-built sequences,
// ID/EX expectations queued at drive time and checked after the edge.
module tb_decode_stage_p;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic        m2r;
      logic        mwr;
      logic        asrc;
      logic        rwr;
      logic [2:0]  alu;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wa;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
   } ex_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        stall;
      logic        flush;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] mem;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [2:0]  redir;
      logic        tgt;
      logic [31:0] pcb;
      logic [31:0] pcj;
      ex_t         e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, pc_plus_4, wb_wr_data, mem_alu_result;
   logic        id_valid, stall_id, flush_ex, wb_wr_en;
   logic [4:0]  wb_wr_addr;
   logic [1:0]  forward_a_id, forward_b_id;
   logic [4:0]  id_rs, id_rt;
   logic        id_branch, id_jump, id_pc_src;
   logic [31:0] id_pc_branch, id_pc_jump;
   logic        ex_valid, ex_illegal, ex_mem_to_reg, ex_mem_wr_en;
   logic        ex_alu_src_sel, ex_reg_wr_en;
   logic [2:0]  ex_alu_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_reg_wr_addr;
   logic [31:0] ex_reg_data1, ex_reg_data2, ex_sign_imm_ext;

   int   total = 0;
   int   bad = 0;
   ex_t  sb[$];
   vec_t tbl[$];
   ex_t  act;

   localparam ex_t BUB = '0;

   always #5 clk = ~clk;

   decode_stage_p dut (
      .clk(clk), .reset(reset), .instr(instr), .pc_plus_4(pc_plus_4),
      .id_valid(id_valid), .stall_id(stall_id), .flush_ex(flush_ex),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
      .wb_wr_data(wb_wr_data), .mem_alu_result(mem_alu_result),
      .forward_a_id(forward_a_id), .forward_b_id(forward_b_id),
      .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch),
      .id_jump(id_jump), .id_pc_src(id_pc_src),
      .id_pc_branch(id_pc_branch), .id_pc_jump(id_pc_jump),
      .ex_valid(ex_valid), .ex_illegal(ex_illegal),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wr_en(ex_mem_wr_en),
      .ex_alu_src_sel(ex_alu_src_sel), .ex_reg_wr_en(ex_reg_wr_en),
      .ex_alu_ctrl(ex_alu_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_reg_wr_addr(ex_reg_wr_addr), .ex_reg_data1(ex_reg_data1),
      .ex_reg_data2(ex_reg_data2), .ex_sign_imm_ext(ex_sign_imm_ext)
   );

   function automatic ex_t mkex(
      input logic v, il, m2r, mwr, asrc, rwr,
      input logic [2:0] alu,
      input logic [4:0] rs, rt, wa,
      input logic [31:0] d1, d2, imm
   );
      return '{v, il, m2r, mwr, asrc, rwr, alu, rs, rt, wa, d1, d2, imm};
   endfunction

   function automatic vec_t mk(
      input logic [31:0] ins, pc4,
      input logic v, st, fl,
      input logic [1:0] fa, fb,
      input logic [31:0] mem,
      input logic wen,
      input logic [4:0] wa,
      input logic [31:0] wd,
      input logic [2:0] redir,
      input ex_t e
   );
      vec_t r;
      r.instr = ins; r.pc4 = pc4; r.valid = v; r.stall = st;
      r.flush = fl; r.fa = fa; r.fb = fb; r.mem = mem; r.wen = wen;
      r.wa = wa; r.wd = wd; r.redir = redir; r.tgt = 1'b0;
      r.pcb = '0; r.pcj = '0; r.e = e;
      return r;
   endfunction

   function automatic ex_t grab();
      return '{ex_valid, ex_illegal, ex_mem_to_reg, ex_mem_wr_en,
               ex_alu_src_sel, ex_reg_wr_en, ex_alu_ctrl, ex_rs, ex_rt,
               ex_reg_wr_addr, ex_reg_data1, ex_reg_data2, ex_sign_imm_ext};
   endfunction

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic apply(input string nm, input vec_t v);
      ex_t exp_e;
      instr = v.instr; pc_plus_4 = v.pc4; id_valid = v.valid;
      stall_id = v.stall; flush_ex = v.flush;
      forward_a_id = v.fa; forward_b_id = v.fb;
      mem_alu_result = v.mem; wb_wr_en = v.wen;
      wb_wr_addr = v.wa; wb_wr_data = v.wd;
      #1;
      chk({nm, ".redir"}, 128'({id_pc_src, id_branch, id_jump}),
          128'(v.redir));
      if (v.tgt) begin
         chk({nm, ".pcb"}, 128'(id_pc_branch), 128'(v.pcb));
         chk({nm, ".pcj"}, 128'(id_pc_jump), 128'(v.pcj));
      end
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      exp_e = sb.pop_front();
      act = grab();
      chk({nm, ".ex"}, 128'(act), 128'(exp_e));
   endtask

   initial begin
      vec_t v, vl;
      ex_t  e3, el;
      reset = 1'b1; instr = '0; pc_plus_4 = '0; id_valid = 1'b0;
      stall_id = 1'b0; flush_ex = 1'b0; wb_wr_en = 1'b0;
      wb_wr_addr = '0; wb_wr_data = '0; mem_alu_result = '0;
      forward_a_id = '0; forward_b_id = '0;
      @(posedge clk);
      #1;
      act = grab();
      chk("reset_state", 128'(act), 128'(BUB));
      reset = 1'b0;

      e3 = mkex(1,0,0,0,0,0,3'b110,0,0,0,32'h1,32'h0,32'h3);
      tbl.push_back(mk(32'h0, 0, 0,0,0, 0,0, 0, 1,5,32'h7, 3'b000, BUB));
      tbl.push_back(mk(32'h00A51820, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b010,5,5,3,32'h7,32'h7,32'h1820)));
      tbl.push_back(mk(32'hAC44FFFC, 0, 1,0,0, 0,0, 0, 1,4,32'h55, 3'b000,
         mkex(1,0,0,1,1,0,3'b010,2,4,0,32'h0,32'h55,32'hFFFFFFFC)));
      v = mk(32'h14000003, 32'h100, 1,0,0, 2'b01,0, 32'h1, 0,0,0,
             3'b110, e3);
      v.tgt = 1; v.pcb = 32'h10C; v.pcj = 32'hC;
      tbl.push_back(v);
      v.stall = 1; v.redir = 3'b000;
      tbl.push_back(v);
      v = mk(32'h10A5FFFF, 32'h200, 1,0,0, 0,0, 0, 0,0,0, 3'b110,
         mkex(1,0,0,0,0,0,3'b110,5,5,0,32'h7,32'h7,32'hFFFFFFFF));
      v.tgt = 1; v.pcb = 32'h1FC; v.pcj = 32'h0297FFFC;
      tbl.push_back(v);
      v = mk(32'h08000040, 32'h10000004, 1,0,0, 0,0, 0, 0,0,0, 3'b001,
         mkex(1,0,0,0,0,0,3'b000,0,0,0,32'h0,32'h0,32'h40));
      v.tgt = 1; v.pcb = 32'h10000104; v.pcj = 32'h10000100;
      tbl.push_back(v);
      tbl.push_back(mk(32'h00A03022, 0, 1,0,0, 0,2'b10, 0, 1,9,32'h20,
         3'b000, mkex(1,0,0,0,0,1,3'b110,5,0,6,32'h7,32'h20,32'h3022)));
      tbl.push_back(mk(32'hFC000000, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,1,0,0,0,0,3'b000,0,0,0,32'h0,32'h0,32'h0)));
      tbl.push_back(mk(32'h00A50001, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,1,0,0,0,0,3'b000,5,5,0,32'h7,32'h7,32'h1)));
      tbl.push_back(mk(32'h8D270008, 0, 1,0,0, 2'b11,0, 0, 0,0,0, 3'b000,
         mkex(1,0,1,0,1,1,3'b010,9,7,7,32'h20,32'h0,32'h8)));
      tbl.push_back(mk(32'h20A8FFFF, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,1,1,3'b010,5,8,8,32'h7,32'h0,32'hFFFFFFFF)));
      tbl.push_back(mk(32'h00A90824, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b000,5,9,1,32'h7,32'h20,32'h824)));
      tbl.push_back(mk(32'h00A90825, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b001,5,9,1,32'h7,32'h20,32'h825)));
      tbl.push_back(mk(32'h00A9082A, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b111,5,9,1,32'h7,32'h20,32'h82A)));
      tbl.push_back(mk(32'h00001820, 0, 1,0,0, 0,0, 0, 1,0,32'hDEAD,
         3'b000, mkex(1,0,0,0,0,1,3'b010,0,0,3,32'h0,32'h0,32'h1820)));
      tbl.push_back(mk(32'h00001820, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b010,0,0,3,32'h0,32'h0,32'h1820)));
      tbl.push_back(mk(32'h00A51820, 0, 1,0,1, 0,0, 0, 0,0,0, 3'b000, BUB));
      tbl.push_back(mk(32'h10A5FFFF, 32'h200, 0,0,0, 0,0, 0, 0,0,0,
         3'b000, BUB));

      foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

      // lw then a 3-cycle stall with changing instructions and a WB write
      el = mkex(1,0,1,0,1,1,3'b010,9,7,7,32'h20,32'h0,32'h8);
      vl = mk(32'h8D270008, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000, el);
      apply("stall_load", vl);
      apply("stall1", mk(32'h00A51820, 0, 1,1,0, 0,0, 0, 1,7,32'h99,
                         3'b000, el));
      apply("stall2", mk(32'hAC44FFFC, 0, 1,1,0, 0,0, 0, 0,0,0,
                         3'b000, el));
      apply("stall3", mk(32'hFC000000, 0, 1,1,0, 0,0, 0, 0,0,0,
                         3'b000, el));
      apply("flush_stall", mk(32'h00A51820, 0, 1,1,1, 0,0, 0, 0,0,0,
                              3'b000, BUB));
      vl.e.d2 = 32'h99;
      apply("lw_r7", vl);

      // async reset between edges, released while stalled
      apply("ill_load", tbl[8]);
      #2 reset = 1'b1;
      stall_id = 1'b1;
      #1;
      act = grab();
      chk("async_reset", 128'(act), 128'(BUB));
      #1 reset = 1'b0;
      apply("rst_stall", mk(32'h00A51820, 0, 1,1,0, 0,0, 0, 0,0,0,
                            3'b000, BUB));
      apply("rst_r5", mk(32'h00A51820, 0, 1,0,0, 0,0, 0, 0,0,0, 3'b000,
         mkex(1,0,0,0,0,1,3'b010,5,5,3,32'h0,32'h0,32'h1820)));

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
